// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared types and constants for the melody sequencer
// Contents: seq_state_t FSM encoding, note code constants, ROM word field positions.

package melody_pkg;

  localparam int ROM_WORD_W = 16;

  localparam int NOTE_MSB = 15;
  localparam int NOTE_LSB = 10;
  localparam int DUR_MSB  = 9;
  localparam int DUR_LSB  = 0;

  localparam logic [5:0] NOTE_REST = 6'h00;
  localparam logic [5:0] NOTE_END  = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_PLAY,
    ST_GAP,
    ST_END
  } seq_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - 1 ms tick prescaler with synchronous clear
// Ports: clk, rst_n (async active-low), clr (restart the period),
//        tick (1-cycle pulse every CLK_FREQ_HZ/1000 clocks).

module ms_tick_gen #(
  parameter  int CLK_FREQ_HZ = 100000000,
  localparam int DIV         = CLK_FREQ_HZ / 1000,
  localparam int CW          = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  // A clear restarts the period, so the first tick lands a full period later.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - song ROM walker driving the SPI DAC master note inputs
// Ports: clk, rst_n (async active-low), start (pulse), stop (abort),
//        rom_addr/rom_data (synchronous song ROM, 1-cycle read latency),
//        note_state/button_action (to SPI master), busy, done (natural end pulse).
// Build option: MELODY_LOOP_EN adds input loop_en to restart the song instead of ending.

module melody_sequencer
  import melody_pkg::*;
#(
  parameter  int CLK_FREQ_HZ = 100000000,
  parameter  int SONG_LEN    = 32,
  parameter  int GAP_MS      = 20,
  localparam int AW          = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1,
  localparam int GW          = $clog2(GAP_MS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
`ifdef MELODY_LOOP_EN
  input  logic                  loop_en,
`endif
  output logic [AW-1:0]         rom_addr,
  input  logic [ROM_WORD_W-1:0] rom_data,
  output logic [5:0]            note_state,
  output logic                  button_action,
  output logic                  busy,
  output logic                  done
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [5:0]    note_q, note_d;
  logic          gate_q, gate_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [9:0]    dur_q, dur_d;
  logic [GW-1:0] gap_q, gap_d;

  logic          tick, tick_clr;
  logic          advance, song_end, last_addr, loop_sel;
  logic [5:0]    rom_note;
  logic [9:0]    rom_dur;

  assign rom_note  = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];
  assign last_addr = (addr_q == AW'(SONG_LEN - 1));

`ifdef MELODY_LOOP_EN
  assign loop_sel = loop_en;
`else
  assign loop_sel = 1'b0;
`endif

  // Restart the ms period whenever a note or a gap begins.
  assign tick_clr = ((state_d == ST_PLAY) && (state_q != ST_PLAY)) ||
                    ((state_d == ST_GAP)  && (state_q != ST_GAP));

  ms_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    gate_d   = gate_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dur_d    = dur_q;
    gap_d    = gap_q;
    advance  = 1'b0;
    song_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (rom_note == NOTE_END)  song_end = 1'b1;
        else if (rom_dur == 10'd0) advance  = 1'b1;
        else begin
          note_d  = rom_note;
          gate_d  = (rom_note != NOTE_REST);
          dur_d   = rom_dur;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          dur_d = dur_q - 10'd1;
          if (dur_q == 10'd1) begin
            gate_d  = 1'b0;
            gap_d   = GW'(GAP_MS);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          gap_d = gap_q - GW'(1);
          if (gap_q == GW'(1)) advance = 1'b1;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (last_addr) song_end = 1'b1;
      else begin
        addr_d  = addr_q + AW'(1);
        state_d = ST_FETCH;
      end
    end

    if (song_end) begin
      if (loop_sel) begin
        addr_d  = '0;
        state_d = ST_FETCH;
      end else begin
        state_d = ST_END;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        note_d  = '0;
        gate_d  = 1'b0;
      end
    end

    // stop overrides everything, including a same-cycle start in IDLE.
    if (stop) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      note_d  = '0;
      gate_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      note_q  <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dur_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
    end
  end

  assign rom_addr      = addr_q;
  assign note_state    = note_q;
  assign button_action = gate_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
